// File: rtl/decoder_session_ctrl_if.sv
// Handshake bundle between a session source and the decoder session controller.
// The master drives the user/function codes and command pulses; the slave
// returns the latched decoder codes and the status flags.
interface decoder_session_ctrl_if;
    logic [2:0] User;
    logic [2:0] Func;
    logic       Login;
    logic       Request;
    logic       Logout;
    logic [2:0] UserOut;
    logic [2:0] FuncOut;
    logic       Enable;
    logic       Denied;
    logic       SessionOpen;
    logic [1:0] State;

    modport master (
        output User, Func, Login, Request, Logout,
        input  UserOut, FuncOut, Enable, Denied, SessionOpen, State
    );

    modport slave (
        input  User, Func, Login, Request, Logout,
        output UserOut, FuncOut, Enable, Denied, SessionOpen, State
    );
endinterface

// File: rtl/decoder_session_ctrl.sv
// Decoder session controller: a user logs in, requests functions that are
// enabled for a fixed hold window, and illegal logins/requests raise Denied
// for a fixed window before returning to the state they came from.
module decoder_session_ctrl #(
    parameter int HOLD_CYCLES = 8,
    parameter int DENY_CYCLES = 4
) (
    input  logic                         Clock,
    input  logic                         Reset,
    decoder_session_ctrl_if.slave        bus
);

    localparam logic [1:0] IDLE    = 2'b00;
    localparam logic [1:0] SESSION = 2'b01;
    localparam logic [1:0] ACTIVE  = 2'b10;
    localparam logic [1:0] DENIED  = 2'b11;

    localparam logic [7:0] HOLD_LOAD = 8'(HOLD_CYCLES - 1);
    localparam logic [7:0] DENY_LOAD = 8'(DENY_CYCLES - 1);

    logic [1:0] state_q, state_nx;
    logic [1:0] ret_q, ret_nx;
    logic [2:0] user_q, user_nx;
    logic [2:0] func_q, func_nx;
    logic [7:0] cnt_q, cnt_nx;
    logic       enable_q, denied_q, open_q;

    function automatic logic user_valid(input logic [2:0] u);
        return (u == 3'b101) || (u == 3'b011) || (u == 3'b001) || (u == 3'b110);
    endfunction

    // Access table: which functions each valid user may activate.
    function automatic logic func_permitted(input logic [2:0] u, input logic [2:0] f);
        logic ok;
        ok = 1'b0;
        case (u)
            3'b101:  ok = (f != 3'b000);
            3'b011:  ok = (f == 3'b001) || (f == 3'b010) || (f == 3'b011) ||
                          (f == 3'b100) || (f == 3'b110);
            3'b001:  ok = (f == 3'b001) || (f == 3'b011) || (f == 3'b100) ||
                          (f == 3'b110);
            3'b110:  ok = (f == 3'b001) || (f == 3'b110);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Next-state logic; one shared counter times both the hold and deny windows.
    always_comb begin
        state_nx = state_q;
        ret_nx   = ret_q;
        user_nx  = user_q;
        func_nx  = func_q;
        cnt_nx   = cnt_q;
        case (state_q)
            IDLE: begin
                if (bus.Login) begin
                    if (user_valid(bus.User)) begin
                        user_nx  = bus.User;
                        state_nx = SESSION;
                    end else begin
                        user_nx  = 3'b000;
                        ret_nx   = IDLE;
                        cnt_nx   = DENY_LOAD;
                        state_nx = DENIED;
                    end
                end
            end
            SESSION: begin
                if (bus.Logout) begin
                    user_nx  = 3'b000;
                    func_nx  = 3'b000;
                    state_nx = IDLE;
                end else if (bus.Request) begin
                    if (func_permitted(user_q, bus.Func)) begin
                        func_nx  = bus.Func;
                        cnt_nx   = HOLD_LOAD;
                        state_nx = ACTIVE;
                    end else begin
                        func_nx  = 3'b000;
                        ret_nx   = SESSION;
                        cnt_nx   = DENY_LOAD;
                        state_nx = DENIED;
                    end
                end
            end
            ACTIVE: begin
                if (bus.Logout) begin
                    user_nx  = 3'b000;
                    func_nx  = 3'b000;
                    cnt_nx   = 8'd0;
                    state_nx = IDLE;
                end else if (cnt_q == 8'd0) begin
                    func_nx  = 3'b000;
                    state_nx = SESSION;
                end else begin
                    cnt_nx = cnt_q - 8'd1;
                end
            end
            default: begin
                // A logout here only redirects the return; the window still runs out.
                if (bus.Logout) begin
                    ret_nx  = IDLE;
                    user_nx = 3'b000;
                end
                if (cnt_q == 8'd0) begin
                    state_nx = ret_nx;
                end else begin
                    cnt_nx = cnt_q - 8'd1;
                end
            end
        endcase
    end

    // State and output registers; flags are registered from the next state.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q  <= IDLE;
            ret_q    <= IDLE;
            user_q   <= 3'b000;
            func_q   <= 3'b000;
            cnt_q    <= 8'd0;
            enable_q <= 1'b0;
            denied_q <= 1'b0;
            open_q   <= 1'b0;
        end else begin
            state_q  <= state_nx;
            ret_q    <= ret_nx;
            user_q   <= user_nx;
            func_q   <= func_nx;
            cnt_q    <= cnt_nx;
            enable_q <= (state_nx == ACTIVE);
            denied_q <= (state_nx == DENIED);
            open_q   <= (state_nx == SESSION) || (state_nx == ACTIVE) ||
                        ((state_nx == DENIED) && (ret_nx == SESSION));
        end
    end

    assign bus.UserOut     = user_q;
    assign bus.FuncOut     = func_q;
    assign bus.Enable      = enable_q;
    assign bus.Denied      = denied_q;
    assign bus.SessionOpen = open_q;
    assign bus.State       = state_q;

endmodule

// File: tb/tb_decoder_session_ctrl.sv
// Scoreboard bench for decoder_session_ctrl: each driven cycle pushes the
// output vector expected after the next rising edge, which is popped and
// compared once the DUT has updated.
module tb_decoder_session_ctrl;

    localparam logic [1:0] S_IDLE    = 2'b00;
    localparam logic [1:0] S_SESSION = 2'b01;
    localparam logic [1:0] S_ACTIVE  = 2'b10;
    localparam logic [1:0] S_DENIED  = 2'b11;

    logic Clock = 1'b0;
    logic Reset = 1'b1;

    int check_count = 0;
    int fail_count  = 0;

    logic [10:0] exp_q[$];

    decoder_session_ctrl_if bus ();

    decoder_session_ctrl #(.HOLD_CYCLES(8), .DENY_CYCLES(4)) dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus.slave)
    );

    // Free-running clock.
    always #5 Clock = ~Clock;

    // Expected vector {State, UserOut, FuncOut, Enable, Denied, SessionOpen}.
    function automatic logic [10:0] ev(input logic [1:0] st, input logic [2:0] u,
                                       input logic [2:0] f, input logic so);
        return {st, u, f, (st == S_ACTIVE), (st == S_DENIED), so};
    endfunction

    task automatic checkOutput(input string tag, input logic [10:0] observed,
                               input logic [10:0] expected);
        check_count++;
        if (observed !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got st=%b u=%b f=%b en=%b den=%b so=%b, want st=%b u=%b f=%b en=%b den=%b so=%b",
                     tag, observed[10:9], observed[8:6], observed[5:3], observed[2], observed[1], observed[0],
                     expected[10:9], expected[8:6], expected[5:3], expected[2], expected[1], expected[0]);
        end
    endtask

    // Drive one cycle of inputs, queue the expectation, compare after the edge.
    task automatic applyStimulus(input string tag, input logic rst,
                                 input logic lg, input logic [2:0] u,
                                 input logic rq, input logic [2:0] f,
                                 input logic lo, input logic [10:0] expv);
        logic [10:0] want;
        Reset       = rst;
        bus.Login   = lg;
        bus.User    = u;
        bus.Request = rq;
        bus.Func    = f;
        bus.Logout  = lo;
        exp_q.push_back(expv);
        @(posedge Clock);
        #1;
        if (exp_q.size() == 0) begin
            check_count++;
            fail_count++;
            $display("[TB] FAIL %s: scoreboard empty, got %b, want an entry", tag, 1'b0);
        end else begin
            want = exp_q.pop_front();
            checkOutput(tag, {bus.State, bus.UserOut, bus.FuncOut,
                              bus.Enable, bus.Denied, bus.SessionOpen}, want);
        end
        Reset       = 1'b0;
        bus.Login   = 1'b0;
        bus.Request = 1'b0;
        bus.Logout  = 1'b0;
    endtask

    task automatic idleCycles(input string tag, input int n, input logic [10:0] expv);
        for (int i = 0; i < n; i++) applyStimulus(tag, 1'b0, 1'b0, 3'b000, 1'b0, 3'b000, 1'b0, expv);
    endtask

    initial begin
        bus.User = 3'b000; bus.Func = 3'b000;
        bus.Login = 1'b0; bus.Request = 1'b0; bus.Logout = 1'b0;

        applyStimulus("reset", 1'b1, 1'b1, 3'b101, 1'b1, 3'b111, 1'b1, ev(S_IDLE, 3'b000, 3'b000, 1'b0));

        // Full activation window for user 101 / func 111, with ignored retriggers.
        applyStimulus("login101", 1'b0, 1'b1, 3'b101, 1'b0, 3'b000, 1'b0, ev(S_SESSION, 3'b101, 3'b000, 1'b1));
        applyStimulus("req111", 1'b0, 1'b0, 3'b000, 1'b1, 3'b111, 1'b0, ev(S_ACTIVE, 3'b101, 3'b111, 1'b1));
        for (int i = 2; i <= 8; i++) begin
            applyStimulus("hold", 1'b0, (i == 5), 3'b011, (i == 3), 3'b001, 1'b0,
                          ev(S_ACTIVE, 3'b101, 3'b111, 1'b1));
        end
        idleCycles("hold_end", 1, ev(S_SESSION, 3'b101, 3'b000, 1'b1));
        applyStimulus("sess_login_ign", 1'b0, 1'b1, 3'b011, 1'b0, 3'b000, 1'b0, ev(S_SESSION, 3'b101, 3'b000, 1'b1));
        applyStimulus("logout", 1'b0, 1'b0, 3'b000, 1'b0, 3'b000, 1'b1, ev(S_IDLE, 3'b000, 3'b000, 1'b0));

        // Non-permitted request returns to SESSION.
        applyStimulus("login110", 1'b0, 1'b1, 3'b110, 1'b0, 3'b000, 1'b0, ev(S_SESSION, 3'b110, 3'b000, 1'b1));
        applyStimulus("req011_deny", 1'b0, 1'b0, 3'b000, 1'b1, 3'b011, 1'b0, ev(S_DENIED, 3'b110, 3'b000, 1'b1));
        idleCycles("deny_sess", 3, ev(S_DENIED, 3'b110, 3'b000, 1'b1));
        idleCycles("deny_back", 1, ev(S_SESSION, 3'b110, 3'b000, 1'b1));
        applyStimulus("logout2", 1'b0, 1'b0, 3'b000, 1'b0, 3'b000, 1'b1, ev(S_IDLE, 3'b000, 3'b000, 1'b0));

        // Invalid user, then idle ignores Request/Logout.
        applyStimulus("login100", 1'b0, 1'b1, 3'b100, 1'b0, 3'b000, 1'b0, ev(S_DENIED, 3'b000, 3'b000, 1'b0));
        idleCycles("deny_idle", 3, ev(S_DENIED, 3'b000, 3'b000, 1'b0));
        idleCycles("deny_idle_back", 1, ev(S_IDLE, 3'b000, 3'b000, 1'b0));
        applyStimulus("idle_req_ign", 1'b0, 1'b0, 3'b000, 1'b1, 3'b001, 1'b1, ev(S_IDLE, 3'b000, 3'b000, 1'b0));

        // Logout on the third ACTIVE cycle.
        applyStimulus("login001", 1'b0, 1'b1, 3'b001, 1'b0, 3'b000, 1'b0, ev(S_SESSION, 3'b001, 3'b000, 1'b1));
        applyStimulus("req010_deny", 1'b0, 1'b0, 3'b000, 1'b1, 3'b010, 1'b0, ev(S_DENIED, 3'b001, 3'b000, 1'b1));
        idleCycles("deny001", 3, ev(S_DENIED, 3'b001, 3'b000, 1'b1));
        idleCycles("deny001_back", 1, ev(S_SESSION, 3'b001, 3'b000, 1'b1));
        applyStimulus("req100", 1'b0, 1'b0, 3'b000, 1'b1, 3'b100, 1'b0, ev(S_ACTIVE, 3'b001, 3'b100, 1'b1));
        idleCycles("act100", 2, ev(S_ACTIVE, 3'b001, 3'b100, 1'b1));
        applyStimulus("act_logout", 1'b0, 1'b0, 3'b000, 1'b1, 3'b011, 1'b1, ev(S_IDLE, 3'b000, 3'b000, 1'b0));

        // Func 000 is never permitted; Logout during DENIED redirects to IDLE.
        applyStimulus("login101b", 1'b0, 1'b1, 3'b101, 1'b0, 3'b000, 1'b0, ev(S_SESSION, 3'b101, 3'b000, 1'b1));
        applyStimulus("req000_deny", 1'b0, 1'b0, 3'b000, 1'b1, 3'b000, 1'b0, ev(S_DENIED, 3'b101, 3'b000, 1'b1));
        applyStimulus("deny_logout", 1'b0, 1'b1, 3'b011, 1'b1, 3'b001, 1'b1, ev(S_DENIED, 3'b000, 3'b000, 1'b0));
        idleCycles("deny_logout_hold", 2, ev(S_DENIED, 3'b000, 3'b000, 1'b0));
        idleCycles("deny_logout_back", 1, ev(S_IDLE, 3'b000, 3'b000, 1'b0));

        // Request and Logout together in SESSION: Logout wins.
        applyStimulus("login011", 1'b0, 1'b1, 3'b011, 1'b0, 3'b000, 1'b0, ev(S_SESSION, 3'b011, 3'b000, 1'b1));
        applyStimulus("req_and_logout", 1'b0, 1'b0, 3'b000, 1'b1, 3'b001, 1'b1, ev(S_IDLE, 3'b000, 3'b000, 1'b0));
        idleCycles("after_rl", 2, ev(S_IDLE, 3'b000, 3'b000, 1'b0));

        // All three pulses in IDLE: only Login is honoured.
        applyStimulus("idle_all3", 1'b0, 1'b1, 3'b011, 1'b1, 3'b110, 1'b1, ev(S_SESSION, 3'b011, 3'b000, 1'b1));

        // Reset in the middle of ACTIVE, then Request without Login.
        applyStimulus("req110", 1'b0, 1'b0, 3'b000, 1'b1, 3'b110, 1'b0, ev(S_ACTIVE, 3'b011, 3'b110, 1'b1));
        idleCycles("act110", 1, ev(S_ACTIVE, 3'b011, 3'b110, 1'b1));
        applyStimulus("reset_active", 1'b1, 1'b0, 3'b000, 1'b1, 3'b110, 1'b1, ev(S_IDLE, 3'b000, 3'b000, 1'b0));
        applyStimulus("req_no_login", 1'b0, 1'b0, 3'b000, 1'b1, 3'b110, 1'b0, ev(S_IDLE, 3'b000, 3'b000, 1'b0));
        idleCycles("post_reset", 2, ev(S_IDLE, 3'b000, 3'b000, 1'b0));

        // Reset in the middle of DENIED clears the window.
        applyStimulus("login111", 1'b0, 1'b1, 3'b111, 1'b0, 3'b000, 1'b0, ev(S_DENIED, 3'b000, 3'b000, 1'b0));
        applyStimulus("reset_denied", 1'b1, 1'b1, 3'b111, 1'b0, 3'b000, 1'b0, ev(S_IDLE, 3'b000, 3'b000, 1'b0));
        idleCycles("post_reset2", 2, ev(S_IDLE, 3'b000, 3'b000, 1'b0));

        // User 110 with its permitted function 001, ended by Logout.
        applyStimulus("login110b", 1'b0, 1'b1, 3'b110, 1'b0, 3'b000, 1'b0, ev(S_SESSION, 3'b110, 3'b000, 1'b1));
        applyStimulus("req001", 1'b0, 1'b0, 3'b000, 1'b1, 3'b001, 1'b0, ev(S_ACTIVE, 3'b110, 3'b001, 1'b1));
        applyStimulus("logout3", 1'b0, 1'b0, 3'b000, 1'b0, 3'b000, 1'b1, ev(S_IDLE, 3'b000, 3'b000, 1'b0));

        $display("TB_RESULT checks=%0d failures=%0d", check_count, fail_count);
        $finish;
    end

endmodule
